// File: rtl/mips32_pkg.sv
// ---------------------------------------------------------------------------
// mips32_pkg
//
// Shared definitions for the MIPS32 core front end:
//   - primary opcode and function-field constants used by fetch and decode
//   - default reset PC
//   - fetch-stage state encoding
//   - helper for the branch displacement (sign-extended, word-scaled)
// ---------------------------------------------------------------------------
package mips32_pkg;

   // Primary opcode field, instruction[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Function field, instruction[5:0], for R-type instructions
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // PC loaded on reset; must be word-aligned
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch-stage states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_ERR  = 2'd3
   } fetch_state_t;

   // Branch displacement: 16-bit immediate sign-extended and scaled to bytes
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage : mips32_pkg

// File: rtl/npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
//
// Purely combinational next-PC selection for the fetch stage.
//
// Ports:
//   pc           in   32  current PC
//   instr_field  in   26  instruction[25:0] (jump target / branch immediate)
//   Read_data_1  in   32  rs value, used as the jr target
//   Branch       in    1  beq from control
//   nBranch      in    1  bne from control
//   Jmp          in    1  j from control
//   Jal          in    1  jal from control
//   Jrn          in    1  jr from control
//   Zero         in    1  ALU equality flag
//   PC_plus_4    out  32  pc + 4, modulo 2^32
//   npc          out  32  selected next PC
//   misaligned   out   1  jr selected with a target that is not word-aligned
//
// Priority when several control lines are active: jr, then j/jal, then a
// taken branch, then sequential.
// ---------------------------------------------------------------------------
module npc_calc
   import mips32_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] instr_field,
   input  logic [31:0] Read_data_1,
   input  logic        Branch,
   input  logic        nBranch,
   input  logic        Jmp,
   input  logic        Jal,
   input  logic        Jrn,
   input  logic        Zero,
   output logic [31:0] PC_plus_4,
   output logic [31:0] npc,
   output logic        misaligned
);

   logic        taken;
   logic [31:0] jump_target;
   logic [31:0] branch_target;

   // Candidate targets. The jump target keeps the upper nibble of the
   // sequential PC, so jumps stay inside the current 256 MB region. Branch
   // arithmetic wraps at 32 bits by construction.
   always_comb begin
      PC_plus_4     = pc + 32'd4;
      jump_target   = {PC_plus_4[31:28], instr_field, 2'b00};
      branch_target = PC_plus_4 + branch_offset(instr_field[15:0]);
      taken         = (Branch & Zero) | (nBranch & ~Zero);
   end

   // Priority select. The misaligned flag only matters when jr wins; the
   // caller uses it to hold the PC and trap instead of taking npc.
   always_comb begin
      npc        = PC_plus_4;
      misaligned = 1'b0;
      if (Jrn) begin
         npc        = Read_data_1;
         misaligned = (Read_data_1[1:0] != 2'b00);
      end else if (Jmp || Jal) begin
         npc = jump_target;
      end else if (taken) begin
         npc = branch_target;
      end
   end

endmodule : npc_calc

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch stage of the MIPS32 core. Owns the PC, fetches one
// instruction word at a time over a req/ack handshake (memory latency may
// vary), holds it for the decoder, and advances the PC when the datapath
// commits the instruction.
//
// Ports:
//   clock            in   1   rising-edge clock
//   reset            in   1   asynchronous, active-low reset
//   imem_req         out  1   fetch request (asserted for the whole S_REQ)
//   imem_addr        out  32  fetch address, always equal to pc
//   imem_ack         in   1   memory response; imem_rdata valid this cycle
//   imem_rdata       in   32  fetched instruction word
//   instruction      out  32  held instruction
//   Opcode           out  6   instruction[31:26]
//   Function_opcode  out  6   instruction[5:0]
//   inst_valid       out  1   instruction held, decoder/datapath may act
//   commit           in   1   datapath done; advance the PC
//   Branch/nBranch/Jmp/Jal/Jrn  in 1  control-decoder outputs
//   Zero             in   1   ALU equality flag
//   Read_data_1      in   32  rs value, jr target
//   pc               out  32  current PC
//   PC_plus_4        out  32  pc + 4, modulo 2^32
//   link_addr        out  32  return address captured on jal
//   addr_err         out  1   sticky: jr target misaligned
// ---------------------------------------------------------------------------
module ifetch_unit
   import mips32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [5:0]  Opcode,
   output logic [5:0]  Function_opcode,
   output logic        inst_valid,
   input  logic        commit,
   input  logic        Branch,
   input  logic        nBranch,
   input  logic        Jmp,
   input  logic        Jal,
   input  logic        Jrn,
   input  logic        Zero,
   input  logic [31:0] Read_data_1,
   output logic [31:0] pc,
   output logic [31:0] PC_plus_4,
   output logic [31:0] link_addr,
   output logic        addr_err
);

   fetch_state_t state;
   fetch_state_t next_state;

   logic [31:0] pc_q;
   logic [31:0] instruction_q;
   logic [31:0] link_q;
   logic [31:0] npc;
   logic        misaligned;

   logic        fetch_done;
   logic        commit_ok;
   logic        commit_trap;

   npc_calc u_npc_calc (
      .pc          (pc_q),
      .instr_field (instruction_q[25:0]),
      .Read_data_1 (Read_data_1),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jrn         (Jrn),
      .Zero        (Zero),
      .PC_plus_4   (PC_plus_4),
      .npc         (npc),
      .misaligned  (misaligned)
   );

   // Qualified handshake events. ack and commit are only meaningful in
   // their own state; a stray pulse elsewhere must not move anything.
   // A commit whose jr target is misaligned traps instead of advancing.
   always_comb begin
      fetch_done  = (state == S_REQ)  && imem_ack;
      commit_ok   = (state == S_EXEC) && commit && !misaligned;
      commit_trap = (state == S_EXEC) && commit &&  misaligned;
   end

   // State register. Reset aborts any fetch or execute in flight; an ack
   // that arrives while reset is held is simply never seen.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. S_REQ waits indefinitely for the memory; S_ERR is
   // only left through reset.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: next_state = S_REQ;
         S_REQ: begin
            if (fetch_done) begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (commit_trap) begin
               next_state = S_ERR;
            end else if (commit_ok) begin
               next_state = S_REQ;
            end
         end
         S_ERR:   next_state = S_ERR;
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath registers. The instruction is captured on the accepted ack
   // and stays stable through S_EXEC (and through S_ERR for debug). The PC
   // only moves on a clean commit; the link register only on a jal commit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         instruction_q <= '0;
         link_q        <= '0;
      end else begin
         if (fetch_done) begin
            instruction_q <= imem_rdata;
         end
         if (commit_ok) begin
            pc_q <= npc;
            if (Jal) begin
               link_q <= PC_plus_4;
            end
         end
      end
   end

   // Outputs. Handshake and valid flags decode from the state register
   // only, so there is no combinational path from any input to them.
   always_comb begin
      imem_req        = (state == S_REQ);
      inst_valid      = (state == S_EXEC);
      addr_err        = (state == S_ERR);
      pc              = pc_q;
      imem_addr       = pc_q;
      instruction     = instruction_q;
      Opcode          = instruction_q[31:26];
      Function_opcode = instruction_q[5:0];
      link_addr       = link_q;
   end

endmodule : ifetch_unit

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the MIPS32 core, directly upstream of the main control decoder.
- Owns the PC and fetches instruction words over a request/acknowledge handshake, so instruction memory may take a variable number of cycles.
- Presents the held instruction, with Opcode and Function_opcode split out, to the decoder.
- Consumes the decoder's Branch/nBranch/Jmp/Jal/Jrn outputs plus the ALU Zero flag to select the next PC, and produces the jal link address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, always equal to pc
imem_ack  in  1  memory response; imem_rdata valid in the same cycle
imem_rdata  in  32  fetched instruction word
instruction  out  32  held instruction
Opcode  out  6  instruction[31:26]
Function_opcode  out  6  instruction[5:0]
inst_valid  out  1  instruction is held and the decoder/datapath may act on it
commit  in  1  datapath done with the current instruction; advance the PC
Branch  in  1  beq from control
nBranch  in  1  bne from control
Jmp  in  1  j from control
Jal  in  1  jal from control
Jrn  in  1  jr from control
Zero  in  1  ALU equality flag
Read_data_1  in  32  rs value, used as the jr target
pc  out  32  current PC
PC_plus_4  out  32  pc+4, modulo 2^32
link_addr  out  32  return address captured on jal
addr_err  out  1  sticky: jr target misaligned

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=S_IDLE, pc=RESET_PC, instruction=0, inst_valid=0
  - imem_req=0, link_addr=0, addr_err=0
- Reset mid-fetch or mid-execute aborts immediately. Any later imem_ack is ignored until the next S_REQ.
- States:
  - S_IDLE: the first clock after reset deasserts -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc. On imem_ack: instruction<=imem_rdata, inst_valid<=1, -> S_EXEC. Otherwise hold, with no timeout.
  - S_EXEC: inst_valid=1; instruction is stable. On commit: pc<=npc, inst_valid<=0, -> S_REQ. Otherwise hold.
  - S_ERR: imem_req=0, inst_valid=0, addr_err=1. Exited only by reset.
- imem_req and inst_valid decode from the state register only; they have no combinational path from inputs.
- imem_ack outside S_REQ is ignored. commit outside S_EXEC is ignored.
- Minimum throughput: 2 cycles per instruction (ack in the first S_REQ cycle, commit in the first S_EXEC cycle).
- Next PC (npc) is evaluated at commit, in priority order:
  1. Jrn: npc=Read_data_1. If Read_data_1[1:0]!=0: pc unchanged, -> S_ERR.
  2. Jmp or Jal: npc={PC_plus_4[31:28], instruction[25:0], 2'b00}.
  3. Branch taken, where taken = (Branch&Zero) | (nBranch&~Zero): npc = PC_plus_4 + (sign_extend(instruction[15:0])<<2), 32-bit wraparound.
  4. Otherwise: npc=PC_plus_4.
- Illegal simultaneous control lines resolve by the priority above (e.g. Jmp and Branch together -> jump).
- Jal at commit: link_addr<=PC_plus_4. link_addr is unchanged on all other instructions.
- PC_plus_4 is combinational from pc. 32'hFFFF_FFFC+4 wraps to 0.
- Opcode and Function_opcode are combinational slices of instruction. They read 0 after reset until the first fetch.

Decomposition:
- Shared package mips32_pkg holds:
  - opcode constants (OP_RTYPE 000000, OP_J 000010, OP_JAL 000011, OP_BEQ 000100, OP_BNE 000101, OP_LW 100011, OP_SW 101011)
  - FUNCT_JR 001000
  - RESET_PC default
  - fetch state enum {S_IDLE, S_REQ, S_EXEC, S_ERR}
- One purely combinational sub-module, npc_calc, computes npc and the misalignment flag from:
  - pc, instruction, Read_data_1
  - Branch, nBranch, Jmp, Jal, Jrn, Zero

Test Plan:
1. Reset release, imem_ack one cycle after imem_req rises, commit with no control lines -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid high for exactly the S_EXEC cycles.
2. pc=0x100, instruction=beq imm=0xFFFE:
   - Branch=1, Zero=1, commit -> pc=0x0FC.
   - Repeat with Zero=0 -> pc=0x104.
   - bne with Zero=0 -> pc=0x0FC.
3. pc=0x0040_0010, jal target field 0x0100000, commit -> pc=0x0040_0000 and link_addr=0x0040_0014. The following j instruction leaves link_addr unchanged.
4. Jrn=1, Read_data_1=0x0000_0203, commit -> addr_err=1, imem_req stays 0, pc holds. Only reset clears addr_err.
5. imem_ack held low for 5 cycles, then high; commit pulsed during S_REQ -> imem_req held the full 6 cycles; the early commit is ignored and pc does not advance.
6. reset asserted in the middle of S_REQ while imem_ack arrives in the same cycle -> outputs at reset values at once; instruction stays 0. After release, the first fetch is at RESET_PC.
